// File: rtl/ysyx_220053_pkg.sv
// Shared constants for the ysyx_220053 front end: opcode fields, IFU state
// encoding and the reset PC.
package ysyx_220053_pkg;

   localparam logic [6:0]  OP_IMM       = 7'b0010011;
   localparam logic [2:0]  F3_ADDI      = 3'b000;
   localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/ysyx_220053_idu_decode.sv
// Combinational field extraction for one 32-bit instruction; only ADDI is
// recognised so far, everything else is reported as illegal.
import ysyx_220053_pkg::*;

module ysyx_220053_idu_decode #(
   parameter int XLEN = 64
) (
   input  logic [31:0]     inst,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic            wen,
   output logic [XLEN-1:0] immI,
   output logic            illegal
);

   logic is_addi;

   assign is_addi = (inst[6:0] == OP_IMM) && (inst[14:12] == F3_ADDI);

   assign rd      = inst[11:7];
   assign rs1     = inst[19:15];
   assign rs2     = inst[24:20];
   assign immI    = {{(XLEN-12){inst[31]}}, inst[31:20]};
   assign wen     = is_addi;
   assign illegal = !is_addi;

endmodule

// File: rtl/ysyx_220053_ifu.sv
// Multi-cycle fetch/decode unit: request, wait for the instruction word,
// then hold the decoded bundle until execute takes it.
//
// state  | meaning
// S_REQ  | request valid at pc, waiting for memory to accept
// S_WAIT | request accepted, waiting for the response (drop=1 discards it)
// S_HOLD | decoded bundle presented, waiting for out_ready
import ysyx_220053_pkg::*;

module ysyx_220053_ifu #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic            out_wen,
   output logic [XLEN-1:0] out_immI,
   output logic            out_illegal
);

   ifu_state_e      state;
   logic [XLEN-1:0] pc;
   logic            drop;
   logic            post_rst;

   logic [XLEN-1:0] target_pc;
   logic [4:0]      dec_rd, dec_rs1, dec_rs2;
   logic            dec_wen, dec_illegal;
   logic [XLEN-1:0] dec_immI;

   assign target_pc      = redirect_pc & ~XLEN'(3);
   assign imem_req_valid = (state == S_REQ) && rst_n;
   assign imem_req_addr  = pc;

   ysyx_220053_idu_decode #(.XLEN(XLEN)) u_decode (
      .inst    (imem_resp_data),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2),
      .wen     (dec_wen),
      .immI    (dec_immI),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         drop        <= 1'b0;
         post_rst    <= 1'b1;
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_rd      <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_wen     <= 1'b0;
         out_immI    <= '0;
         out_illegal <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (imem_req_ready) begin
                  post_rst <= 1'b0;
                  state    <= S_WAIT;
               end
               if (redirect_valid) begin
                  pc <= target_pc;
                  if (imem_req_ready) drop <= 1'b1;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc <= target_pc;
                  // a response in the same cycle belongs to the old path
                  if (imem_resp_valid) begin
                     drop  <= 1'b0;
                     state <= S_REQ;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (imem_resp_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= S_REQ;
                  end else begin
                     out_valid   <= 1'b1;
                     out_pc      <= pc;
                     out_rd      <= dec_rd;
                     out_rs1     <= dec_rs1;
                     out_rs2     <= dec_rs2;
                     out_wen     <= dec_wen;
                     out_immI    <= dec_immI;
                     out_illegal <= dec_illegal;
                     state       <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  out_valid <= 1'b0;
                  pc        <= target_pc;
                  state     <= S_REQ;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  pc        <= pc + XLEN'(4);
                  state     <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

   // A response still in flight across a reset may land before the next request.
   a_resp_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
      imem_resp_valid |-> ((state == S_WAIT) || post_rst));

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed bench for ysyx_220053_ifu: stimulus pushes expected fetch
// addresses and decoded bundles; monitors pop and compare on handshakes.
module tb_ysyx_220053_ifu;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        wen;
      logic [63:0] imm;
      logic        ill;
   } bundle_t;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic        out_wen;
   logic [63:0] out_immI;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_addrs[$];
   bundle_t     exp_bundles[$];

   ysyx_220053_ifu dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_rd          (out_rd),
      .out_rs1         (out_rs1),
      .out_rs2         (out_rs2),
      .out_wen         (out_wen),
      .out_immI        (out_immI),
      .out_illegal     (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bundle_t mk(input logic [63:0] pc, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic wen, input logic [63:0] imm, input logic ill);
      bundle_t b;
      b.pc = pc; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
      b.wen = wen; b.imm = imm; b.ill = ill;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one-cycle accept window; the DUT must already be in S_REQ
   task automatic do_req();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
   endtask

   task automatic do_resp(input logic [31:0] data);
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      tick();
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
   endtask

   // request-channel monitor
   initial begin
      forever begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            if (exp_addrs.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_req: got %h expected none", imem_req_addr);
            end else begin
               check("req_addr", imem_req_addr, exp_addrs.pop_front());
            end
         end
      end
   end

   // decoded-bundle monitor
   initial begin
      bundle_t act, exp;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            act = mk(out_pc, out_rd, out_rs1, out_rs2, out_wen, out_immI, out_illegal);
            n_checks++;
            if (exp_bundles.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_bundle: got %h expected none", act);
            end else begin
               exp = exp_bundles.pop_front();
               if (act !== exp) begin
                  n_fail++;
                  $display("FAIL bundle: got %h expected %h", act, exp);
               end
            end
         end
      end
   end

   // out_valid must rise exactly one cycle after a response
   initial begin
      logic prev_ov = 1'b0;
      logic prev_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !prev_ov) check("latency_resp_prev_cycle", 64'(prev_resp), 64'd1);
         prev_ov   = out_valid;
         prev_resp = imem_resp_valid;
      end
   end

   initial begin
      rst_n           = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      redirect_valid  = 1'b0;
      redirect_pc     = 64'h0;
      out_ready       = 1'b1;

      tick(); tick();
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_immI", out_immI, 64'd0);
      check("rst_out_fields", {out_rd, out_rs1, out_rs2, out_wen, out_illegal}, 64'd0);
      rst_n = 1'b1;
      tick();
      check("rst_req_addr", imem_req_addr, 64'h8000_0000);
      check("rst_req_valid_after", 64'(imem_req_valid), 64'd1);

      // addi x1,x0,5 with zero-wait memory and ready consumer
      exp_addrs.push_back(64'h8000_0000);
      exp_bundles.push_back(mk(64'h8000_0000, 5'd1, 5'd0, 5'd5, 1'b1, 64'd5, 1'b0));
      do_req();
      do_resp(32'h0050_0093);
      tick();
      check("t1_next_addr", imem_req_addr, 64'h8000_0004);
      check("t1_out_valid_clear", 64'(out_valid), 64'd0);

      // addi x2,x2,-1 held for 4 cycles
      out_ready = 1'b0;
      exp_addrs.push_back(64'h8000_0004);
      exp_bundles.push_back(mk(64'h8000_0004, 5'd2, 5'd2, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0));
      do_req();
      do_resp(32'hFFF1_0113);
      for (int i = 0; i < 4; i++) begin
         check("t2_hold_valid", 64'(out_valid), 64'd1);
         check("t2_hold_immI", out_immI, 64'hFFFF_FFFF_FFFF_FFFF);
         check("t2_hold_pc", out_pc, 64'h8000_0004);
         check("t2_hold_regs", {out_rd, out_rs1, out_rs2}, {49'd0, 5'd2, 5'd2, 5'd31});
         check("t2_hold_no_req", 64'(imem_req_valid), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("t2_next_addr", imem_req_addr, 64'h8000_0008);

      // ecall is not supported
      exp_addrs.push_back(64'h8000_0008);
      exp_bundles.push_back(mk(64'h8000_0008, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1));
      do_req();
      do_resp(32'h0000_0073);
      tick();

      // redirect while waiting; the old response must vanish
      exp_addrs.push_back(64'h8000_000C);
      do_req();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1002;
      tick();
      redirect_valid = 1'b0;
      do_resp(32'h0050_0093);
      check("t4_drop_no_valid", 64'(out_valid), 64'd0);
      tick();
      check("t4_drop_no_valid2", 64'(out_valid), 64'd0);
      check("t4_redirect_addr", imem_req_addr, 64'h8000_1000);
      exp_addrs.push_back(64'h8000_1000);
      exp_bundles.push_back(mk(64'h8000_1000, 5'd1, 5'd0, 5'd10, 1'b1, 64'd10, 1'b0));
      do_req();
      do_resp(32'h00A0_0093);
      tick();

      // redirect in S_HOLD together with out_ready
      out_ready = 1'b0;
      exp_addrs.push_back(64'h8000_1004);
      exp_bundles.push_back(mk(64'h8000_1004, 5'd1, 5'd0, 5'd5, 1'b1, 64'd5, 1'b0));
      do_req();
      do_resp(32'h0050_0093);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      tick();
      redirect_valid = 1'b0;
      check("t5_valid_drop", 64'(out_valid), 64'd0);
      check("t5_redirect_addr", imem_req_addr, 64'h8000_2000);
      exp_addrs.push_back(64'h8000_2000);
      exp_bundles.push_back(mk(64'h8000_2000, 5'd1, 5'd0, 5'd5, 1'b1, 64'd5, 1'b0));
      do_req();
      do_resp(32'h0050_0093);
      tick();
      check("t5_after_addr", imem_req_addr, 64'h8000_2004);

      // redirect in S_REQ (low bits forced clear), then PC wrap
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      check("t6_redirect_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      exp_addrs.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_bundles.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 5'd0, 5'd5, 1'b1, 64'd5, 1'b0));
      do_req();
      do_resp(32'h0050_0093);
      tick();
      check("t6_wrap_addr", imem_req_addr, 64'h0);
      check("t6_wrap_req_valid", 64'(imem_req_valid), 64'd1);

      // reset while waiting; the late response is ignored
      exp_addrs.push_back(64'h0);
      do_req();
      rst_n = 1'b0;
      tick();
      check("t7_rst_req_valid", 64'(imem_req_valid), 64'd0);
      rst_n = 1'b1;
      check("t7_rst_addr", imem_req_addr, 64'h8000_0000);
      do_resp(32'h0050_0093);
      check("t7_late_no_valid", 64'(out_valid), 64'd0);
      tick();
      check("t7_late_no_valid2", 64'(out_valid), 64'd0);
      check("t7_addr_kept", imem_req_addr, 64'h8000_0000);
      exp_addrs.push_back(64'h8000_0000);
      exp_bundles.push_back(mk(64'h8000_0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1));
      do_req();
      do_resp(32'h0000_0073);
      tick();
      tick();

      check("addr_queue_drained", 64'(exp_addrs.size()), 64'd0);
      check("bundle_queue_drained", 64'(exp_bundles.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
